// File: rtl/seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier with start/valid handshake.
// Scans the multiplier LSB first and stops once no set multiplier bits remain.
module seq_multiplier #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          CACHING  = 1'b0,
  parameter bit          INIT_VLD = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic [WIDTH-1:0]   multiplier_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic               overflow_o,
  output logic               valid_o
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic {StIdle, StCalc} state_e;

  state_e           state_q;
  logic [PW-1:0]    product_q;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic             valid_en_q;
  logic             op_zero;
  logic             cache_hit;

  assign op_zero = (multiplicand_i == '0) || (multiplier_i == '0);

  if (CACHING) begin : g_cache
    logic [WIDTH-1:0] cache_a_q;
    logic [WIDTH-1:0] cache_b_q;

    // The zero shortcut takes priority, so a zero operand never counts as a hit.
    assign cache_hit = !op_zero && (multiplicand_i == cache_a_q) &&
                       (multiplier_i == cache_b_q);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cache_a_q <= '0;
        cache_b_q <= '0;
      end else if ((state_q == StIdle) && start_i && !cache_hit) begin
        cache_a_q <= multiplicand_i;
        cache_b_q <= multiplier_i;
      end
    end
  end else begin : g_no_cache
    assign cache_hit = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      product_q  <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      valid_en_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            valid_en_q <= 1'b1;
            if (op_zero) begin
              product_q <= '0;
            end else if (!cache_hit) begin
              mcand_q   <= {{WIDTH{1'b0}}, multiplicand_i};
              mplier_q  <= multiplier_i;
              product_q <= '0;
              state_q   <= StCalc;
            end
          end
        end
        StCalc: begin
          if (mplier_q[0]) begin
            product_q <= product_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if ((mplier_q >> 1) == '0) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign product_o  = product_q;
  assign overflow_o = |product_q[PW-1:WIDTH];
  // A start pulse in IDLE withdraws valid in the same cycle.
  assign valid_o    = (state_q == StIdle) && !start_i && (INIT_VLD || valid_en_q);

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: a 32-bit plain instance and an 8-bit
// instance with caching and initial-valid, both checked against arithmetic.
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] prod;
    logic        ovf;
    int unsigned lat;
    int unsigned t0;
  } exp_t;

  // Instance A: WIDTH=32, no caching, valid only after first start.
  logic        a_rst = 1'b1, a_start = 1'b0;
  logic [31:0] a_mcand = '0, a_mplier = '0;
  logic [63:0] a_prod;
  logic        a_ovf, a_vld;

  // Instance B: WIDTH=8, caching, valid allowed right after reset.
  logic        b_rst = 1'b1, b_start = 1'b1;
  logic [7:0]  b_mcand = '0, b_mplier = '0;
  logic [15:0] b_prod;
  logic        b_ovf, b_vld;

  seq_multiplier #(.WIDTH(32), .CACHING(1'b0), .INIT_VLD(1'b0)) u_dut_a (
    .clk_i          (clk),
    .rst_i          (a_rst),
    .start_i        (a_start),
    .multiplicand_i (a_mcand),
    .multiplier_i   (a_mplier),
    .product_o      (a_prod),
    .overflow_o     (a_ovf),
    .valid_o        (a_vld)
  );

  seq_multiplier #(.WIDTH(8), .CACHING(1'b1), .INIT_VLD(1'b1)) u_dut_b (
    .clk_i          (clk),
    .rst_i          (b_rst),
    .start_i        (b_start),
    .multiplicand_i (b_mcand),
    .multiplier_i   (b_mplier),
    .product_o      (b_prod),
    .overflow_o     (b_ovf),
    .valid_o        (b_vld)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycles from the start cycle until valid: one per multiplier bit up to its MSB, plus one.
  function automatic int unsigned calc_lat(input logic [63:0] b);
    int unsigned m = 0;
    for (int i = 0; i < 64; i++) if (b[i]) m = i;
    return m + 2;
  endfunction

  exp_t qa[$];
  exp_t qb[$];
  exp_t a_e, b_e;
  logic a_vld_prev = 1'b0, b_vld_prev = 1'b0;
  bit   a_mon_en = 1'b0, b_mon_en = 1'b0;
  logic [7:0] mc_a = '0, mc_b = '0;

  always @(negedge clk) begin
    if (a_mon_en && a_vld && !a_vld_prev) begin
      if (qa.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL a_spurious_valid: got valid=1 expected no pending result");
      end else begin
        a_e = qa.pop_front();
        chk("a_product", a_prod, a_e.prod);
        chk("a_overflow", 64'(a_ovf), 64'(a_e.ovf));
        chk("a_latency", 64'(cyc - a_e.t0), 64'(a_e.lat));
      end
    end
    a_vld_prev = a_vld;
  end

  always @(negedge clk) begin
    if (b_mon_en && b_vld && !b_vld_prev) begin
      if (qb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL b_spurious_valid: got valid=1 expected no pending result");
      end else begin
        b_e = qb.pop_front();
        chk("b_product", 64'(b_prod), b_e.prod);
        chk("b_overflow", 64'(b_ovf), 64'(b_e.ovf));
        chk("b_latency", 64'(cyc - b_e.t0), 64'(b_e.lat));
      end
    end
    b_vld_prev = b_vld;
  end

  task automatic wait_a();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!a_vld && k < 100);
    chk("a_done_in_time", 64'(a_vld), 64'd1);
  endtask

  task automatic wait_b();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!b_vld && k < 100);
    chk("b_done_in_time", 64'(b_vld), 64'd1);
  endtask

  task automatic start_a(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.prod = {32'd0, a} * {32'd0, b};
    e.ovf  = |e.prod[63:32];
    e.lat  = (a == 0 || b == 0) ? 1 : calc_lat(64'(b));
    @(posedge clk); #1;
    a_mcand = a; a_mplier = b; a_start = 1'b1;
    e.t0 = cyc;
    qa.push_back(e);
    @(posedge clk); #1;
    a_start = 1'b0; a_mcand = $urandom; a_mplier = $urandom;
  endtask

  task automatic issue_a(input logic [31:0] a, input logic [31:0] b);
    start_a(a, b);
    wait_a();
  endtask

  task automatic issue_b(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic [15:0] p;
    p      = {8'd0, a} * {8'd0, b};
    e.prod = 64'(p);
    e.ovf  = |p[15:8];
    if (a == 0 || b == 0) begin
      e.lat = 1; mc_a = a; mc_b = b;
    end else if (a == mc_a && b == mc_b) begin
      e.lat = 1;
    end else begin
      e.lat = calc_lat(64'(b)); mc_a = a; mc_b = b;
    end
    @(posedge clk); #1;
    b_mcand = a; b_mplier = b; b_start = 1'b1;
    e.t0 = cyc;
    qb.push_back(e);
    @(posedge clk); #1;
    b_start = 1'b0; b_mcand = 8'($urandom); b_mplier = 8'($urandom);
    wait_b();
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [7:0]  sa, sb;

    // ---------------- Instance A ----------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("a_reset_valid", 64'(a_vld), 64'd0);
    chk("a_reset_product", a_prod, 64'd0);
    chk("a_reset_overflow", 64'(a_ovf), 64'd0);
    @(posedge clk); #1 a_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("a_no_valid_before_start", 64'(a_vld), 64'd0);
    a_mon_en = 1'b1;

    issue_a(32'd6, 32'd7);
    issue_a(32'd0, 32'd123);
    issue_a(32'd123, 32'd0);
    issue_a(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 20; i++) begin
      ra = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
      rb = 32'($urandom) >> $urandom_range(0, 31);
      issue_a(ra, rb);
    end

    // Start pulse during CALC must be ignored.
    start_a(32'd200, 32'd100000);
    repeat (4) @(posedge clk);
    #1 a_start = 1'b1; a_mcand = 32'd1; a_mplier = 32'd1;
    @(posedge clk); #1 a_start = 1'b0;
    wait_a();
    chk("a_ignored_start_product", a_prod, 64'd20000000);

    // Reset in the middle of a run.
    @(posedge clk); #1;
    a_mcand = 32'd200; a_mplier = 32'd100000; a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    repeat (5) @(posedge clk);
    #1 a_rst = 1'b1;
    @(posedge clk); #1 a_rst = 1'b0;
    @(negedge clk);
    chk("a_midrun_reset_product", a_prod, 64'd0);
    chk("a_midrun_reset_valid", 64'(a_vld), 64'd0);
    repeat (20) @(negedge clk);
    chk("a_after_reset_valid_low", 64'(a_vld), 64'd0);
    chk("a_after_reset_product_held", a_prod, 64'd0);
    issue_a(32'd3, 32'd5);

    // ---------------- Instance B ----------------
    // Reset held with start high: valid suppressed; start low: valid at once.
    @(negedge clk);
    chk("b_reset_start_high_valid", 64'(b_vld), 64'd0);
    b_start = 1'b0;
    #1;
    chk("b_reset_start_low_valid", 64'(b_vld), 64'd1);
    chk("b_reset_product", 64'(b_prod), 64'd0);
    chk("b_reset_overflow", 64'(b_ovf), 64'd0);
    @(posedge clk); #1 b_rst = 1'b0;
    @(negedge clk);
    chk("b_init_valid_after_reset", 64'(b_vld), 64'd1);
    b_mon_en = 1'b1;

    issue_b(8'd255, 8'd255);
    issue_b(8'd16, 8'd17);
    issue_b(8'd3, 8'd1);
    issue_b(8'd6, 8'd7);
    issue_b(8'd6, 8'd7);
    issue_b(8'd6, 8'd8);
    issue_b(8'd0, 8'd5);
    issue_b(8'd0, 8'd5);
    issue_b(8'd9, 8'd13);
    issue_b(8'd9, 8'd13);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        sa = 8'($urandom_range(0, 3));
        sb = 8'($urandom_range(0, 3));
      end else begin
        sa = 8'($urandom);
        sb = 8'($urandom);
      end
      issue_b(sa, sb);
    end

    repeat (5) @(negedge clk);
    chk("a_queue_empty", 64'(qa.size()), 64'd0);
    chk("b_queue_empty", 64'(qb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected completion before timeout");
    $fatal(1, "watchdog expired");
  end

endmodule
